fp32_issue_seq: RTL

Request-side sequencer for the pipelined FP32 product unit. Accepts a batch command (base index, count), drives one `start`/`idx` request per cycle into the product unit, and collects the returned `ready`/`out_bits` words in order into an internal result FIFO with a valid/ready output. The product unit has no backpressure, so this block issues only against guaranteed FIFO space (credit scheme). It sits between LSTM gate control and the FP32 product pipe.

---
 rtl/fp32_issue_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fp32_issue_seq.sv
// Request-side sequencer for the pipelined FP32 product unit: issues indexed requests under FIFO credit
// and collects returns in order. Optional watchdog abort is enabled with `define FP32_ISSUE_TIMEOUT_EN.
module fp32_issue_seq #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_base,
  input  logic [15:0] cmd_count,
  output logic        mul_start,
  output logic [31:0] mul_idx,
  input  logic        mul_ready,
  input  logic [31:0] mul_bits,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_bits,
  output logic        res_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);
  // Handshakes: cmd_* and res_* transfer on a rising edge where valid && ready are both high;
  // valid never waits on ready. mul_start/mul_ready are one-cycle strobes with no backpressure.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   base_q;
  logic [15:0]   count_q;
  logic [15:0]   issued_q;
  logic [15:0]   returned_q;
  logic [CW-1:0] in_flight_q;
  logic [CW-1:0] fifo_count_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [31:0]   hold_bits_q;

  logic          accept;
  logic          zero_cmd;
  logic          issue_now;
  logic          ret_ok;
  logic          push;
  logic          pop;
  logic          head_last;
  logic          last_tag;
  logic          last_pop;
  logic          abort;
  logic [SW-1:0] credit_used;

  assign accept      = (state == S_IDLE) && cmd_valid;
  assign zero_cmd    = accept && (cmd_count == 16'd0);
  assign credit_used = {1'b0, in_flight_q} + {1'b0, fifo_count_q};
  assign ret_ok      = mul_ready && (in_flight_q != '0);
  assign push        = ret_ok && !abort;
  assign pop         = res_valid && res_ready;
  assign head_last   = mem[rd_ptr_q][32];
  assign last_tag    = (returned_q == count_q - 16'd1);
  assign last_pop    = (state == S_DRAIN) && pop && head_last && (returned_q == count_q);

  // A request is only issued when a FIFO slot is already reserved for its return.
  always_comb begin
    issue_now = 1'b0;
    if (accept) begin
      issue_now = !zero_cmd;
    end else if ((state == S_ISSUE) && (issued_q != count_q) &&
                 (credit_used < SW'(FIFO_DEPTH))) begin
      issue_now = !abort;
    end
  end

`ifdef FP32_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q;
  logic          err_q;

  assign abort = (in_flight_q != '0) && !mul_ready && (wd_q == TW'(TIMEOUT - 1));
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= 1'b0;
      end else if (abort) begin
        err_q <= 1'b1;
      end
      if (abort || accept || mul_ready || (in_flight_q == '0)) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + TW'(1);
      end
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && !zero_cmd) begin
          state_nxt = (cmd_count == 16'd1) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (issue_now && (issued_q + 16'd1 == count_q)) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort || last_pop) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q       <= '0;
      count_q      <= '0;
      issued_q     <= '0;
      returned_q   <= '0;
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_bits_q  <= '0;
      mul_start    <= 1'b0;
      mul_idx      <= '0;
      done         <= 1'b0;
    end else begin
      mul_start <= issue_now;
      done      <= zero_cmd || last_pop;
      if (issue_now) begin
        mul_idx <= accept ? cmd_base : base_q + {16'd0, issued_q};
      end
      if (accept) begin
        base_q     <= cmd_base;
        count_q    <= cmd_count;
        issued_q   <= issue_now ? 16'd1 : 16'd0;
        returned_q <= '0;
      end else begin
        if (issue_now) begin
          issued_q <= issued_q + 16'd1;
        end
        if (push) begin
          returned_q <= returned_q + 16'd1;
        end
      end
      // Abort drops everything outstanding; returns that still arrive see in_flight == 0.
      if (abort) begin
        in_flight_q  <= '0;
        fifo_count_q <= '0;
        rd_ptr_q     <= wr_ptr_q;
      end else begin
        in_flight_q  <= in_flight_q + CW'(issue_now) - CW'(ret_ok);
        fifo_count_q <= fifo_count_q + CW'(push) - CW'(pop);
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q    <= rd_ptr_q + AW'(1);
          hold_bits_q <= mem[rd_ptr_q][31:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {last_tag, mul_bits};
    end
  end

  assign res_valid = (fifo_count_q != '0);
  assign res_bits  = res_valid ? mem[rd_ptr_q][31:0] : hold_bits_q;
  assign res_last  = res_valid && head_last;

endmodule
